// File: rtl/iram_loader.sv
// Byte-stream to AXI4-Lite write master: packs bytes little-endian into words
// and writes them to consecutive word addresses of an instruction RAM window.
module iram_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          LIMIT_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    input  logic        flush_i,
    input  logic        restart_i,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [15:0] word_cnt_o,
    output logic        busy_o,
    output logic        err_o,
    output logic        ovf_o
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    // One past the last loadable byte; 33 bits so a window ending at 4 GiB still compares correctly.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(LIMIT_BYTES);

    logic [1:0]  state_r;
    logic [2:0]  byte_cnt_r;
    logic [31:0] buf_r;
    logic [31:0] addr_r;
    logic [3:0]  wstrb_r;
    logic        awvalid_r;
    logic        wvalid_r;
    logic        bready_r;
    logic        byte_ready_r;
    logic        aw_done_r;
    logic        w_done_r;
    logic [15:0] word_cnt_r;
    logic        err_r;
    logic        ovf_r;

    logic        accept_s;
    logic [31:0] next_buf_s;
    logic [2:0]  next_cnt_s;
    logic        trigger_s;
    logic        in_window_s;
    logic        aw_fin_s;
    logic        w_fin_s;

    function automatic logic [3:0] lane_strobe(input logic [2:0] cnt);
        logic [3:0] strb;
        case (cnt)
            3'd1:    strb = 4'h1;
            3'd2:    strb = 4'h3;
            3'd3:    strb = 4'h7;
            default: strb = 4'hF;
        endcase
        return strb;
    endfunction

    assign accept_s    = byte_valid_i & byte_ready_r;
    assign trigger_s   = (next_cnt_s == 3'd4) | (flush_i & (next_cnt_s != 3'd0));
    assign in_window_s = ({1'b0, addr_r} < END_ADDR);
    assign aw_fin_s    = aw_done_r | (awvalid_r & m_axi_awready);
    assign w_fin_s     = w_done_r | (wvalid_r & m_axi_wready);

    // Buffer and lane count as they would be after this cycle's byte is taken.
    always_comb begin
        next_buf_s = buf_r;
        next_cnt_s = byte_cnt_r;
        if (accept_s) begin
            next_buf_s = buf_r | ({24'h00_0000, byte_i} << {byte_cnt_r[1:0], 3'b000});
            next_cnt_s = byte_cnt_r + 3'd1;
        end else begin
            next_buf_s = buf_r;
            next_cnt_s = byte_cnt_r;
        end
    end

    // Collect / write / response sequencing with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_COLLECT;
            byte_cnt_r   <= 3'd0;
            buf_r        <= 32'h0000_0000;
            addr_r       <= BASE_ADDR;
            wstrb_r      <= 4'h0;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            bready_r     <= 1'b0;
            byte_ready_r <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            word_cnt_r   <= 16'h0000;
            err_r        <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (restart_i) begin
                        addr_r       <= BASE_ADDR;
                        word_cnt_r   <= 16'h0000;
                        err_r        <= 1'b0;
                        ovf_r        <= 1'b0;
                        byte_cnt_r   <= 3'd0;
                        buf_r        <= 32'h0000_0000;
                        byte_ready_r <= 1'b1;
                    end else if (trigger_s && in_window_s) begin
                        state_r      <= ST_WRITE;
                        buf_r        <= next_buf_s;
                        byte_cnt_r   <= next_cnt_s;
                        wstrb_r      <= lane_strobe(next_cnt_s);
                        awvalid_r    <= 1'b1;
                        wvalid_r     <= 1'b1;
                        aw_done_r    <= 1'b0;
                        w_done_r     <= 1'b0;
                        byte_ready_r <= 1'b0;
                    end else if (trigger_s) begin
                        // Word lies beyond the window: drop it, keep addr and count.
                        ovf_r        <= 1'b1;
                        buf_r        <= 32'h0000_0000;
                        byte_cnt_r   <= 3'd0;
                        byte_ready_r <= 1'b1;
                    end else begin
                        buf_r        <= next_buf_s;
                        byte_cnt_r   <= next_cnt_s;
                        byte_ready_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    byte_ready_r <= 1'b0;
                    if (awvalid_r && m_axi_awready) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (wvalid_r && m_axi_wready) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_r  <= ST_RESP;
                        bready_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid && bready_r) begin
                        if (m_axi_bresp != 2'b00) begin
                            err_r <= 1'b1;
                        end
                        // A failed word is skipped, never retried.
                        addr_r       <= addr_r + 32'd4;
                        word_cnt_r   <= word_cnt_r + 16'd1;
                        buf_r        <= 32'h0000_0000;
                        byte_cnt_r   <= 3'd0;
                        bready_r     <= 1'b0;
                        byte_ready_r <= 1'b1;
                        state_r      <= ST_COLLECT;
                    end else begin
                        byte_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_COLLECT;
                    awvalid_r    <= 1'b0;
                    wvalid_r     <= 1'b0;
                    bready_r     <= 1'b0;
                    byte_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready_o  = byte_ready_r;
    assign m_axi_awaddr  = addr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = buf_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign word_cnt_o    = word_cnt_r;
    assign err_o         = err_r;
    assign ovf_o         = ovf_r;
    assign busy_o        = (state_r != ST_COLLECT) | (byte_cnt_r != 3'd0);

endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: table of word/flush vectors, an AXI slave model with
// configurable ready delays, and a write scoreboard; a second instance with an 8-byte window.
module tb_iram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_i;
    logic        byte_valid, flush, restart;
    logic        byte_ready_o;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic [15:0] word_cnt_o;
    logic        busy_o, err_o, ovf_o;

    logic [31:0] s_awaddr, s_wdata;
    logic [2:0]  s_awprot;
    logic        s_awvalid, s_wvalid, s_bready, s_byte_ready, s_busy, s_err, s_ovf;
    logic [3:0]  s_wstrb;
    logic [15:0] s_word_cnt;

    always #5 clk = ~clk;

    iram_loader #(.BASE_ADDR(32'h0000_0000), .LIMIT_BYTES(16384)) dut (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready_o), .flush_i(flush), .restart_i(restart),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .word_cnt_o(word_cnt_o),
        .busy_o(busy_o), .err_o(err_o), .ovf_o(ovf_o)
    );

    // Small-window instance runs in lockstep off the same stimulus and slave.
    iram_loader #(.BASE_ADDR(32'h0000_0000), .LIMIT_BYTES(8)) dut_small (
        .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid),
        .byte_ready_o(s_byte_ready), .flush_i(flush), .restart_i(restart),
        .m_axi_awaddr(s_awaddr), .m_axi_awprot(s_awprot),
        .m_axi_awvalid(s_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(s_wdata), .m_axi_wstrb(s_wstrb),
        .m_axi_wvalid(s_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(s_bready), .word_cnt_o(s_word_cnt),
        .busy_o(s_busy), .err_o(s_err), .ovf_o(s_ovf)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
    typedef struct { int n; logic [31:0] bytes; int fmode; logic [31:0] exp_data; logic [3:0] exp_strb; } vec_t;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    wr_t exp_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    int aw_rise[$];
    logic [31:0] exp_addr = 32'h0;
    int exp_wcnt = 0;
    int aw_delay = 0, w_delay = 0;
    logic [1:0] bresp_val = 2'b00;
    logic aw_pend = 1'b0, w_pend = 1'b0, b_take = 1'b0;
    int cnt_awv, cnt_wv, cnt_brd, cnt_bad, cnt_wr, small_aw_cnt;
    logic prev_awv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave model: readies after a programmable wait, bvalid one cycle after both handshakes.
    initial begin
        int aw_wait, w_wait;
        aw_wait = 0; w_wait = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
                aw_wait = 0; w_wait = 0; aw_pend = 1'b0; w_pend = 1'b0; b_take = 1'b0;
            end else begin
                if (b_take) begin m_axi_bvalid = 1'b0; b_take = 1'b0; end
                if (aw_pend && w_pend) begin
                    m_axi_bvalid = 1'b1; m_axi_bresp = bresp_val; aw_pend = 1'b0; w_pend = 1'b0;
                end
                if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
                else begin m_axi_awready = 1'b0; aw_wait = 0; end
                if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
                else begin m_axi_wready = 1'b0; w_wait = 0; end
            end
        end
    end

    // Monitor: collect handshakes, pair address with data, compare against expectations.
    initial begin
        wr_t e;
        logic [31:0] a;
        logic [35:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_axi_awvalid && m_axi_awready) begin aw_q.push_back(m_axi_awaddr); aw_pend = 1'b1; end
                if (m_axi_wvalid && m_axi_wready) begin w_q.push_back({m_axi_wstrb, m_axi_wdata}); w_pend = 1'b1; end
                if (m_axi_bvalid && m_axi_bready) b_take = 1'b1;
                if (m_axi_awvalid) cnt_awv++;
                if (m_axi_wvalid) cnt_wv++;
                if (m_axi_bready) cnt_brd++;
                if (byte_ready_o && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) cnt_bad++;
                if (s_awvalid) small_aw_cnt++;
                if (m_axi_awvalid && !prev_awv) aw_rise.push_back(cyc);
                prev_awv = m_axi_awvalid;
                while (aw_q.size() > 0 && w_q.size() > 0) begin
                    a = aw_q.pop_front();
                    w = w_q.pop_front();
                    cnt_wr++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_write: got addr=%h data=%h strb=%h expected none", a, w[31:0], w[35:32]);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e.addr || w[31:0] !== e.data || w[35:32] !== e.strb) begin
                            miscompares++;
                            $display("FAIL axi_write: got addr=%h data=%h strb=%h expected addr=%h data=%h strb=%h",
                                     a, w[31:0], w[35:32], e.addr, e.data, e.strb);
                        end
                    end
                end
            end else begin
                prev_awv = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] data, input logic [3:0] strb);
        wr_t e;
        e.addr = exp_addr; e.data = data; e.strb = strb;
        exp_q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        exp_wcnt++;
    endtask

    // Holds byte_valid until accepted; leaves byte_valid high so streams stay back-to-back.
    task automatic send_byte(input logic [7:0] b, input logic fl, output int acc);
        logic done;
        done = 1'b0;
        acc = -1;
        byte_i = b; byte_valid = 1'b1; flush = fl;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (byte_ready_o) begin acc = cyc; done = 1'b1; end
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        if (!done) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic stop_bytes();
        byte_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pulse(input int which);
        if (which == 0) flush = 1'b1; else restart = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; restart = 1'b0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (!busy_o && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int acc;
        push_exp(w, 4'hF);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0, acc);
        stop_bytes();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic [7:0] sbytes[64];
        int acc[64];
        int a_tmp;
        logic [31:0] wd;

        vecs[0] = '{4, 32'h0000_0013, 0, 32'h0000_0013, 4'hF};
        vecs[1] = '{4, 32'h0010_0093, 0, 32'h0010_0093, 4'hF};
        vecs[2] = '{2, 32'h0000_BBAA, 2, 32'h0000_BBAA, 4'h3};
        vecs[3] = '{1, 32'h0000_0055, 1, 32'h0000_0055, 4'h1};
        vecs[4] = '{3, 32'h0033_2211, 1, 32'h0033_2211, 4'h7};
        vecs[5] = '{4, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 4'hF};

        rst = 1'b1; byte_i = 8'h00; byte_valid = 1'b0; flush = 1'b0; restart = 1'b0;
        cnt_awv = 0; cnt_wv = 0; cnt_brd = 0; cnt_bad = 0; cnt_wr = 0; small_aw_cnt = 0;
        repeat (2) @(negedge clk);
        chk("reset_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        chk("reset_flags", {28'd0, byte_ready_o, busy_o, err_o, ovf_o}, 32'd0);
        chk("reset_word_cnt", {16'd0, word_cnt_o}, 32'd0);
        chk("reset_awaddr", m_axi_awaddr, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ready_after_reset", {31'd0, byte_ready_o}, 32'd1);
        chk("awprot", {29'd0, m_axi_awprot}, 32'd0);
        @(posedge clk); #1;

        // Table: full words, partial words flushed with the last byte or as a separate pulse.
        for (int i = 0; i < 6; i++) begin
            push_exp(vecs[i].exp_data, vecs[i].exp_strb);
            for (int k = 0; k < vecs[i].n; k++)
                send_byte(vecs[i].bytes[8*k +: 8], (vecs[i].fmode == 1) && (k == vecs[i].n - 1), a_tmp);
            stop_bytes();
            if (vecs[i].fmode == 2) pulse(0);
            wait_idle();
            chk("word_cnt_table", {16'd0, word_cnt_o}, exp_wcnt);
            chk("err_table", {31'd0, err_o}, 32'd0);
        end

        // Flush with an empty buffer does nothing.
        pulse(0);
        repeat (3) @(negedge clk);
        chk("empty_flush_busy", {31'd0, busy_o}, 32'd0);
        @(posedge clk); #1;

        // Error response: sticky err, address and count still advance.
        bresp_val = 2'b10;
        send_word(32'h1122_3344);
        wait_idle();
        bresp_val = 2'b00;
        chk("err_set", {31'd0, err_o}, 32'd1);
        chk("err_word_cnt", {16'd0, word_cnt_o}, exp_wcnt);
        send_word(32'h5566_7788);
        wait_idle();
        chk("err_sticky", {31'd0, err_o}, 32'd1);
        pulse(1);
        exp_addr = 32'h0; exp_wcnt = 0;
        @(negedge clk);
        chk("restart_err", {31'd0, err_o}, 32'd0);
        chk("restart_word_cnt", {16'd0, word_cnt_o}, 32'd0);
        chk("restart_addr", m_axi_awaddr, 32'h0);
        @(posedge clk); #1;

        // awready three cycles ahead of wready.
        aw_delay = 0; w_delay = 3;
        cnt_awv = 0; cnt_wv = 0; cnt_brd = 0; cnt_bad = 0; cnt_wr = 0;
        send_word(32'hCAFE_F00D);
        wait_idle();
        w_delay = 0;
        chk("skew_awvalid_cycles", cnt_awv, 32'd1);
        chk("skew_wvalid_cycles", cnt_wv, 32'd4);
        chk("skew_bready_cycles", cnt_brd, 32'd1);
        chk("skew_ready_while_busy", cnt_bad, 32'd0);
        chk("skew_write_count", cnt_wr, 32'd1);

        // Continuous 64-byte stream with timing checks.
        for (int i = 0; i < 64; i++) sbytes[i] = 8'($urandom_range(0, 255));
        for (int k = 0; k < 16; k++) begin
            wd = {sbytes[4*k+3], sbytes[4*k+2], sbytes[4*k+1], sbytes[4*k]};
            push_exp(wd, 4'hF);
        end
        aw_rise.delete();
        for (int i = 0; i < 64; i++) send_byte(sbytes[i], 1'b0, acc[i]);
        stop_bytes();
        wait_idle();
        chk("stream_word_cnt", {16'd0, word_cnt_o}, exp_wcnt);
        chk("stream_aw_count", aw_rise.size(), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) chk("stream_ready_gap", acc[4*k] - acc[4*k-1], 32'd3);
            if (k < aw_rise.size()) chk("stream_aw_latency", aw_rise[k] - acc[4*k+3], 32'd1);
        end

        // Reset during a stalled write drops the valids at once.
        aw_delay = 50; w_delay = 50;
        for (int k = 0; k < 4; k++) send_byte(8'h5A, 1'b0, a_tmp);
        stop_bytes();
        repeat (2) @(negedge clk);
        chk("midwrite_awvalid", {31'd0, m_axi_awvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midwrite_reset_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 32'd0);
        chk("midwrite_reset_busy", {31'd0, busy_o}, 32'd0);
        aw_delay = 0; w_delay = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_addr = 32'h0; exp_wcnt = 0;
        @(posedge clk); @(posedge clk); #1;

        // 8-byte window: third word is dropped by the small instance.
        small_aw_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            wd = 32'h0302_0100 + {4{8'(4*k)}};
            push_exp(wd, 4'hF);
            for (int j = 0; j < 4; j++) send_byte(wd[8*j +: 8], 1'b0, a_tmp);
        end
        stop_bytes();
        wait_idle();
        chk("ovf_flag", {31'd0, s_ovf}, 32'd1);
        chk("ovf_word_cnt", {16'd0, s_word_cnt}, 32'd2);
        chk("ovf_aw_cycles", small_aw_cnt, 32'd2);
        chk("ovf_busy", {31'd0, s_busy}, 32'd0);
        chk("ovf_addr", s_awaddr, 32'h8);
        chk("main_word_cnt", {16'd0, word_cnt_o}, 32'd3);

        chk("pending_writes", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
